spi_cmd_decoder: RTL and testbench
==================================

# spi_cmd_decoder

- Sits directly downstream of the SPI byte transceiver (`spi_trx`).
- Turns the received byte stream into 16-bit register read/write transactions on a simple register-bus master port.
- Feeds response bytes back to the transceiver's transmit latch.
- One SPI frame (SS low) carries one command byte followed by an auto-incrementing burst of 16-bit words, sent MSB byte first.

## Interface
Parameters:
- `ADDR_W`, 7: register address width; the command byte carries the address in bits [6:0].
- `STATUS_BYTE`, 8'hA5: byte returned on MISO during byte 1 of every frame.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `frame_rst_i`  in  1  one-cycle pulse at frame start; connects to transceiver `rst_o`.
- `rx_data_i`  in  8  received byte; connects to `data_o`.
- `rx_ack_i`  in  1  one-cycle strobe, `rx_data_i` valid; connects to `ack_pop_o`.
- `tx_data_o`  out  8  next byte to transmit; connects to `data_i`.
- `tx_ack_o`  out  1  one-cycle strobe that loads `tx_data_o` into the transceiver latch; connects to `ack_i`.
- `reg_addr_o`  out  ADDR_W  register address.
- `reg_wdata_o`  out  16  write data.
- `reg_we_o`  out  1  one-cycle write strobe.
- `reg_re_o`  out  1  one-cycle read strobe.
- `reg_rdata_i`  in  16  read data; valid exactly one cycle after `reg_re_o`.

## Operation
Command byte format:
- Bit 7 = 1: write. Bit 7 = 0: read.
- Bits [6:0] = start address.

State machine:
- States: IDLE, WR_HI, WR_LO, RD_FETCH, RD_HI, RD_LO.
- IDLE, on `rx_ack_i`: latch the address.
  - Bit 7 = 1: go to WR_HI.
  - Bit 7 = 0: go to RD_FETCH.
- WR_HI, on `rx_ack_i`: capture the high byte; go to WR_LO.
- WR_LO, on `rx_ack_i`:
  - Pulse `reg_we_o` with `reg_wdata_o` = {hi, rx_data_i} at the current address.
  - Increment the address; go to WR_HI.
- RD_FETCH:
  - Pulse `reg_re_o` for one cycle.
  - Next cycle: capture `reg_rdata_i`, push its high byte (`tx_ack_o`), go to RD_HI.
- RD_HI, on `rx_ack_i`: push the held low byte; go to RD_LO.
- RD_LO, on `rx_ack_i`: increment the address; go to RD_FETCH.

Transmit path:
- The cycle after `frame_rst_i`, push `STATUS_BYTE`.
- In IDLE/WR_* states, every `rx_ack_i` also pushes `STATUS_BYTE`.

Address arithmetic:
- The address counter is ADDR_W bits and wraps modulo 2^ADDR_W (127 -> 0).
- Bit 7 of later bytes is never reinterpreted as a command.

Frame restart:
- `frame_rst_i` has priority over `rx_ack_i` and over every state: go to IDLE and clear the held high byte.
- A write whose low byte has not arrived is discarded; no `reg_we_o` is issued.
- An in-flight RD_FETCH is abandoned: the `reg_re_o` already issued is harmless, and its data is dropped.

## Timing
- Resulting MISO per frame: byte 0 don't-care; byte 1 `STATUS_BYTE`.
  - Read frames: bytes 2,3 = word[addr] hi, lo; bytes 4,5 = word[addr+1]; and so on.
  - Write frames: every byte after byte 1 is `STATUS_BYTE`.
- Write latency: `reg_we_o` asserts in the cycle after the low byte's `rx_ack_i`.
- Read latency: `reg_re_o` asserts 1 cycle after the triggering `rx_ack_i`; `tx_ack_o` asserts 2 cycles after it.
  - This must complete well within one SPI byte time. With the transceiver's 2-stage synchronisers this requires clk ≥ 8×SCK.
- Strobes: `tx_ack_o`, `reg_we_o` and `reg_re_o` are registered one-cycle pulses. `reg_we_o` and `reg_re_o` are never both high.
- Reset values:
  - State IDLE.
  - All strobes 0.
  - `tx_data_o` = `STATUS_BYTE`.
  - `reg_addr_o` = 0.
  - `reg_wdata_o` = 0.
- Reset mid-frame: the block returns to IDLE asynchronously and issues no strobe until the next `rx_ack_i` or `frame_rst_i`.
- Simultaneous `frame_rst_i` and `rx_ack_i`: the byte is dropped.

## Configuration
Macro: `SPI_CMD_READ_EN`.
- Defined: read path present, exactly as above.
- Undefined:
  - RD_* states are not built.
  - A read command is treated as a write-ignored frame: the block stays in a sink state until `frame_rst_i`.
  - `reg_re_o` is tied 0, and every pushed byte is `STATUS_BYTE`.
  - `reg_rdata_i` is unused.

## Structure
- Shared package `spi_cmd_pkg`:
  - state encoding;
  - command bit position constant (CMD_WR_BIT = 7);
  - default `STATUS_BYTE`;
  - register word width (16).
- No sub-module: a single FSM with an address counter and a byte-hold register. The register file it drives is a separate, existing block.

## Test plan
- Write burst: frame with bytes 0x85, 0x12, 0x34, 0xAB, 0xCD -> `reg_we_o` at addr 5 with 0x1234, then at addr 6 with 0xABCD; MISO bytes 1-4 = 0xA5.
- Read burst: regs[0x10]=0xBEEF, regs[0x11]=0x0102; send 0x10 plus 5 dummy bytes -> MISO bytes 1..5 = A5, BE, EF, 01, 02; `reg_re_o` at addr 0x10 then 0x11.
- Wrap: write frame starting at addr 0x7F with 2 words -> writes at 0x7F, then 0x00.
- Truncated write: 0x83, 0x55, then SS rises and a new frame starts -> no `reg_we_o`; the next frame decodes its byte 0 as a command.
- Reset mid-read: assert `rst` during RD_LO -> all strobes low, `tx_data_o` = 0xA5; the next frame behaves normally.
- Config off: with `SPI_CMD_READ_EN` undefined, a read frame 0x10 plus 4 bytes -> no `reg_re_o`, no `reg_we_o`, MISO bytes 1..4 = 0xA5.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command decoder.
package spi_cmd_pkg;

  localparam int          CMD_WR_BIT     = 7;
  localparam int          WORD_W         = 16;
  localparam logic [7:0]  STATUS_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_HI,
    ST_WR_LO,
    ST_RD_FETCH,
    ST_RD_HI,
    ST_RD_LO,
    ST_SINK
  } state_t;

endpackage

// File: rtl/spi_cmd_decoder.sv
// SPI byte stream to 16-bit register bus bridge; read path built only with SPI_CMD_READ_EN.
//
// state    | meaning
// IDLE     | waiting for command byte
// WR_HI    | waiting for write high byte
// WR_LO    | waiting for write low byte, then write strobe
// RD_FETCH | read strobe issued, then capture read data and push high byte
// RD_HI    | high byte pushed, push held low byte on next byte
// RD_LO    | low byte pushed, advance address and fetch on next byte
// SINK     | read command with read path absent, ignore rest of frame
import spi_cmd_pkg::*;

module spi_cmd_decoder #(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = STATUS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ack_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_ack_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [WORD_W-1:0] reg_wdata_o,
  output logic              reg_we_o,
  output logic              reg_re_o,
  input  logic [WORD_W-1:0] reg_rdata_i
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          hold_q, hold_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_ack_q, tx_ack_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                rd_tx_q, rd_tx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_rst_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_ack_i) begin
`ifdef SPI_CMD_READ_EN
          state_d = rx_data_i[CMD_WR_BIT] ? ST_WR_HI : ST_RD_FETCH;
`else
          state_d = rx_data_i[CMD_WR_BIT] ? ST_WR_HI : ST_SINK;
`endif
        end
        ST_WR_HI: if (rx_ack_i) state_d = ST_WR_LO;
        ST_WR_LO: if (rx_ack_i) state_d = ST_WR_HI;
`ifdef SPI_CMD_READ_EN
        // re_q marks the first RD_FETCH cycle; read data is valid in the second
        ST_RD_FETCH: if (!re_q) state_d = ST_RD_HI;
        ST_RD_HI:    if (rx_ack_i) state_d = ST_RD_LO;
        ST_RD_LO:    if (rx_ack_i) state_d = ST_RD_FETCH;
`else
        ST_SINK:     state_d = ST_SINK;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    addr_d    = addr_q;
    hold_d    = hold_q;
    wdata_d   = wdata_q;
    tx_data_d = tx_data_q;
    tx_ack_d  = 1'b0;
    we_d      = 1'b0;
    re_d      = 1'b0;
    rd_tx_d   = 1'b0;
    // write address advances after the strobe cycle so the strobe sees the current address
    if (we_q) addr_d = addr_q + 1'b1;
    if (frame_rst_i) begin
      hold_d    = '0;
      tx_data_d = STATUS_BYTE;
      tx_ack_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_ack_i) begin
          addr_d = rx_data_i[ADDR_W-1:0];
`ifdef SPI_CMD_READ_EN
          if (rx_data_i[CMD_WR_BIT]) begin
            tx_data_d = STATUS_BYTE;
            tx_ack_d  = 1'b1;
          end else begin
            re_d = 1'b1;
          end
`else
          tx_data_d = STATUS_BYTE;
          tx_ack_d  = 1'b1;
`endif
        end
        ST_WR_HI: if (rx_ack_i) begin
          hold_d    = rx_data_i;
          tx_data_d = STATUS_BYTE;
          tx_ack_d  = 1'b1;
        end
        ST_WR_LO: if (rx_ack_i) begin
          we_d      = 1'b1;
          wdata_d   = {hold_q, rx_data_i};
          tx_data_d = STATUS_BYTE;
          tx_ack_d  = 1'b1;
        end
`ifdef SPI_CMD_READ_EN
        ST_RD_FETCH: begin
          if (re_q) begin
            tx_ack_d = 1'b1;
            rd_tx_d  = 1'b1;
          end else begin
            tx_data_d = reg_rdata_i[15:8];
            hold_d    = reg_rdata_i[7:0];
          end
        end
        ST_RD_HI: if (rx_ack_i) begin
          tx_data_d = hold_q;
          tx_ack_d  = 1'b1;
        end
        ST_RD_LO: if (rx_ack_i) begin
          addr_d = addr_q + 1'b1;
          re_d   = 1'b1;
        end
`else
        ST_SINK: if (rx_ack_i) begin
          tx_data_d = STATUS_BYTE;
          tx_ack_d  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      hold_q    <= '0;
      wdata_q   <= '0;
      tx_data_q <= STATUS_BYTE;
      tx_ack_q  <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_tx_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      wdata_q   <= wdata_d;
      tx_data_q <= tx_data_d;
      tx_ack_q  <= tx_ack_d;
      we_q      <= we_d;
      re_q      <= re_d;
      rd_tx_q   <= rd_tx_d;
    end
  end

  assign tx_ack_o    = tx_ack_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;

`ifdef SPI_CMD_READ_EN
  // read data is forwarded in its valid cycle, then held from tx_data_q
  assign tx_data_o = rd_tx_q ? reg_rdata_i[15:8] : tx_data_q;
  assign reg_re_o  = re_q;
`else
  logic unused_rd;
  assign unused_rd = ^{reg_rdata_i, re_q, rd_tx_q};
  assign tx_data_o = tx_data_q;
  assign reg_re_o  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Randomized self-checking bench for spi_cmd_decoder against a frame-level reference model.
module tb_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_rst_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_ack_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_ack_o;
  logic [6:0]  reg_addr_o;
  logic [15:0] reg_wdata_o;
  logic        reg_we_o;
  logic        reg_re_o;
  logic [15:0] reg_rdata_i = 16'h0000;

  spi_cmd_decoder dut (
    .clk(clk), .rst(rst), .frame_rst_i(frame_rst_i), .rx_data_i(rx_data_i),
    .rx_ack_i(rx_ack_i), .tx_data_o(tx_data_o), .tx_ack_o(tx_ack_o),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o),
    .reg_re_o(reg_re_o), .reg_rdata_i(reg_rdata_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rx = 0;
  bit fetch_pend = 0;
  bit both_seen = 0;

  logic [15:0] mem_env [128];
  logic [15:0] ref_mem [128];
  logic [7:0]  fq [$];
  logic [7:0]  exp_tx [$];
  logic [7:0]  obs_tx [$];
  int          exp_wa [$], exp_wd [$], exp_ra [$];
  int          obs_wa [$], obs_wd [$], obs_ra [$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // environment register file: one-cycle read latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reg_we_o) mem_env[reg_addr_o] <= reg_wdata_o;
    if (reg_re_o) reg_rdata_i <= mem_env[reg_addr_o];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_ack_i) last_rx = cyc;
      if (frame_rst_i) fetch_pend = 0;
      if (reg_we_o && reg_re_o) both_seen = 1;
      if (reg_we_o) begin
        obs_wa.push_back(int'(reg_addr_o));
        obs_wd.push_back(int'(reg_wdata_o));
        chk("we_lat", cyc - last_rx, 1);
      end
      if (reg_re_o) begin
        obs_ra.push_back(int'(reg_addr_o));
        chk("re_lat", cyc - last_rx, 1);
        fetch_pend = 1;
      end else if (tx_ack_o && fetch_pend) begin
        chk("tx_lat", cyc - last_rx, 2);
        fetch_pend = 0;
      end
      if (tx_ack_o) obs_tx.push_back(tx_data_o);
    end
  end

  // Frame-level expectations: each byte produces one push, words stream MSB first.
  task automatic model_frame();
    int n, a;
    logic [7:0] c;
    logic [15:0] w;
    exp_tx.delete(); exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    exp_tx.push_back(8'hA5);
    n = fq.size();
    if (n == 0) return;
    c = fq[0];
    a = int'(c[6:0]);
    if (c[7]) begin
      for (int k = 0; k < n; k++) exp_tx.push_back(8'hA5);
      for (int j = 0; 2*j + 2 <= n - 1; j++) begin
        w = {fq[2*j+1], fq[2*j+2]};
        exp_wa.push_back((a + j) % 128);
        exp_wd.push_back(int'(w));
        ref_mem[(a + j) % 128] = w;
      end
    end else begin
`ifdef SPI_CMD_READ_EN
      for (int k = 0; k < n; k++) begin
        w = ref_mem[(a + k/2) % 128];
        exp_tx.push_back((k % 2 == 0) ? w[15:8] : w[7:0]);
      end
      for (int j = 0; 2*j <= n - 1; j++) exp_ra.push_back((a + j) % 128);
`else
      for (int k = 0; k < n; k++) exp_tx.push_back(8'hA5);
`endif
    end
  endtask

  task automatic clear_obs();
    obs_tx.delete(); obs_wa.delete(); obs_wd.delete(); obs_ra.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1 rx_data_i = b; rx_ack_i = 1'b1;
    @(posedge clk); #1 rx_ack_i = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic frame_start(input bit collide);
    @(posedge clk); #1 frame_rst_i = 1'b1;
    if (collide) begin rx_data_i = 8'(($urandom % 128) | 128); rx_ack_i = 1'b1; end
    @(posedge clk); #1 frame_rst_i = 1'b0; rx_ack_i = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic run_frame(input string tag, input bit collide);
    model_frame();
    frame_start(collide);
    foreach (fq[i]) send_byte(fq[i]);
    repeat (10) @(posedge clk);
    chk({tag, "_ntx"}, obs_tx.size(), exp_tx.size());
    for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++)
      chk({tag, "_tx"}, int'(obs_tx[i]), int'(exp_tx[i]));
    chk({tag, "_nwe"}, obs_wa.size(), exp_wa.size());
    for (int i = 0; i < obs_wa.size() && i < exp_wa.size(); i++) begin
      chk({tag, "_wa"}, obs_wa[i], exp_wa[i]);
      chk({tag, "_wd"}, obs_wd[i], exp_wd[i]);
    end
    chk({tag, "_nre"}, obs_ra.size(), exp_ra.size());
    for (int i = 0; i < obs_ra.size() && i < exp_ra.size(); i++)
      chk({tag, "_ra"}, obs_ra[i], exp_ra[i]);
    chk({tag, "_excl"}, int'(both_seen), 0);
    clear_obs();
  endtask

  task automatic add(input logic [7:0] b);
    fq.push_back(b);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_tx_ack"}, int'(tx_ack_o), 0);
    chk({tag, "_we"}, int'(reg_we_o), 0);
    chk({tag, "_re"}, int'(reg_re_o), 0);
    chk({tag, "_txd"}, int'(tx_data_o), 8'hA5);
    chk({tag, "_addr"}, int'(reg_addr_o), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 128; i++) begin
      v = 16'($urandom);
      mem_env[i] = v;
      ref_mem[i] = v;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_wdata", int'(reg_wdata_o), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    fq.delete(); add(8'h85); add(8'h12); add(8'h34); add(8'hAB); add(8'hCD);
    run_frame("wr_burst", 0);

    mem_env[16] = 16'hBEEF; ref_mem[16] = 16'hBEEF;
    mem_env[17] = 16'h0102; ref_mem[17] = 16'h0102;
    fq.delete(); add(8'h10); for (int i = 0; i < 5; i++) add(8'(i * 37 + 200));
    run_frame("rd_burst", 0);

    fq.delete(); add(8'hFF); add(8'h11); add(8'h22); add(8'h33); add(8'h44);
    run_frame("wrap", 0);

    fq.delete(); add(8'h83); add(8'h55);
    run_frame("trunc", 0);
    fq.delete(); add(8'h90); add(8'hC3); add(8'h3C);
    run_frame("after_trunc", 0);

    fq.delete(); add(8'h88); add(8'h77); add(8'h66);
    run_frame("collide", 1);

    // reset while in RD_LO
    frame_start(0);
    send_byte(8'h20);
    send_byte(8'h00);
    #3 rst = 1'b1;
    #1 check_idle_outputs("rst_mid");
    clear_obs();
    fetch_pend = 0;
    @(posedge clk); #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    chk("rst_quiet", obs_tx.size() + obs_wa.size() + obs_ra.size(), 0);
    fq.delete(); add(8'h20); add(8'h01); add(8'h02); add(8'h03);
    run_frame("after_rst", 0);

    for (int f = 0; f < 30; f++) begin
      fq.delete();
      add(8'($urandom));
      for (int i = 0; i < int'($urandom_range(0, 7)); i++) add(8'($urandom));
      run_frame("rand", ($urandom % 8) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
